// File: rtl/debounce_pkg.sv
// Shared defaults and the per-channel strobe bundle for the debounce_multi conditioner.
package debounce_pkg;

  localparam int DEF_CNT_W         = 3;
  localparam int DEF_HOLD_W        = 16;
  localparam int DEF_HOLD_CYCLES   = 50000;
  localparam int DEF_REPEAT_CYCLES = 10000;

  typedef struct packed {
    logic down;
    logic up;
    logic hold;
    logic rpt;
  } strb_t;

endpackage

// File: rtl/debounce_ch.sv
// One push-button channel: 2-FF synchroniser, stability counter, press/release/hold strobes.
// Auto-repeat counter is built only when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int HOLD_W        = DEF_HOLD_W,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_pb,
  output logic  o_state,
  output logic  o_state_nxt,
  output strb_t o_strb
);

  if (CNT_W < 1 || HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** HOLD_W) - 1 ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > (2 ** HOLD_W) - 1) begin : g_param_err
    $error("debounce_ch: CNT_W, HOLD_CYCLES or REPEAT_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_TC  = HOLD_W'(HOLD_CYCLES);

  logic              r_s0, r_s1, r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_hold_done;
  logic              r_down, r_up, r_hold;
  logic              w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_hold_fire;
  logic              w_rpt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    if (r_s1 != r_state) begin
      if (r_cnt == '1) w_state_nxt = ~r_state;
      else             w_cnt_nxt   = r_cnt + CNT_ONE;
    end
  end

  // Gating with w_state_nxt keeps pb_hold out of the pb_up cycle.
  assign w_hold_fire = r_state & w_state_nxt & ~r_hold_done & (r_hold_cnt == HOLD_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
      r_state     <= 1'b0;
      r_cnt       <= '0;
      r_hold_cnt  <= '0;
      r_hold_done <= 1'b0;
      r_down      <= 1'b0;
      r_up        <= 1'b0;
      r_hold      <= 1'b0;
    end else begin
      r_s0    <= i_pb ^ ACTIVE_LOW;
      r_s1    <= r_s0;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_down  <= w_state_nxt & ~r_state;
      r_up    <= ~w_state_nxt & r_state;
      r_hold  <= w_hold_fire;
      if (!r_state) begin
        r_hold_cnt  <= '0;
        r_hold_done <= 1'b0;
      end else begin
        if (r_hold_cnt != '1) r_hold_cnt <= r_hold_cnt + HOLD_ONE;
        if (w_hold_fire)      r_hold_done <= 1'b1;
      end
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] REP_LOAD = HOLD_W'(REPEAT_CYCLES - 1);

  logic              r_rep_run;
  logic [HOLD_W-1:0] r_rep_cnt;
  logic              r_rpt;

  // Down-counter is loaded on the same edge that raises pb_hold, so terminal count lands REPEAT_CYCLES later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_run <= 1'b0;
      r_rep_cnt <= '0;
      r_rpt     <= 1'b0;
    end else begin
      r_rpt <= 1'b0;
      if (!r_state) begin
        r_rep_run <= 1'b0;
        r_rep_cnt <= '0;
      end else if (w_hold_fire) begin
        r_rep_run <= 1'b1;
        r_rep_cnt <= REP_LOAD;
      end else if (r_rep_run) begin
        if (r_rep_cnt == '0) begin
          r_rep_cnt <= REP_LOAD;
          r_rpt     <= w_state_nxt;
        end else begin
          r_rep_cnt <= r_rep_cnt - HOLD_ONE;
        end
      end
    end
  end

  assign w_rpt = r_rpt;
`else
  assign w_rpt = 1'b0;
`endif

  assign o_state     = r_state;
  assign o_state_nxt = w_state_nxt;
  assign o_strb      = {r_down, r_up, r_hold, w_rpt};

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: one debounce_ch per input plus a registered any_pressed.
// Optional auto-repeat strobes are enabled by DEBOUNCE_AUTOREPEAT_EN.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CNT_W         = DEF_CNT_W,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int HOLD_W        = DEF_HOLD_W,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_state,
  output logic [N_CH-1:0] pb_down,
  output logic [N_CH-1:0] pb_up,
  output logic [N_CH-1:0] pb_hold,
  output logic [N_CH-1:0] pb_repeat,
  output logic            any_pressed
);

  logic [N_CH-1:0] w_state_nxt;
  strb_t           w_strb [N_CH];
  logic            r_any;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .CNT_W         (CNT_W),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .HOLD_W        (HOLD_W),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_pb        (pb_in[g]),
      .o_state     (pb_state[g]),
      .o_state_nxt (w_state_nxt[g]),
      .o_strb      (w_strb[g])
    );

    assign pb_down[g]   = w_strb[g].down;
    assign pb_up[g]     = w_strb[g].up;
    assign pb_hold[g]   = w_strb[g].hold;
    assign pb_repeat[g] = w_strb[g].rpt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_any <= 1'b0;
    else        r_any <= |w_state_nxt;
  end

  assign any_pressed = r_any;

endmodule
